// File: rtl/fsm_lockstep_sequencer.sv
// fsm_lockstep_sequencer: runs three FSM copies in lockstep against a golden next-state model
// Ports: clk, reset (async, active-high); start/pattern/len run request; s_beh/s_gate/s_rom FSM outputs;
//   fsm_rst_n/fsm_a drive the FSMs; busy/done status; error/err_cnt/err_step/err_mask/exp_state results.
module fsm_lockstep_sequencer #(
  parameter int PAT_W   = 32,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 8,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [2:0]       s_beh,
  input  logic [2:0]       s_gate,
  input  logic [2:0]       s_rom,
  output logic             fsm_rst_n,
  output logic             fsm_a,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] err_cnt,
  output logic [LEN_W-1:0] err_step,
  output logic [2:0]       err_mask,
  output logic [2:0]       exp_state
);
  localparam int RC_W = $clog2(RST_CYC + 1);
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  state_t state, nstate;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] nsteps, k, k_n, len_c;
  logic [RC_W-1:0]  rc;
  logic [2:0]       mask;
  logic             accept, mis, a_n;

  function automatic logic [2:0] gnext(input logic [2:0] s, input logic a);
    case (s)
      3'd2:    gnext = 3'd6;
      3'd6:    gnext = a ? 3'd7 : 3'd4;
      3'd4:    gnext = 3'd5;
      3'd5:    gnext = a ? 3'd6 : 3'd2;
      3'd7:    gnext = 3'd4;
      default: gnext = 3'd2;
    endcase
  endfunction

  always_comb begin
    accept = state == IDLE && start;
    len_c  = len > LEN_W'(PAT_W) ? LEN_W'(PAT_W) : len;
    k_n    = state == RUN ? k + LEN_W'(1) : '0;
    a_n    = |(pat & (PAT_W'(1) << k_n));
    mask   = {s_rom != exp_state, s_gate != exp_state, s_beh != exp_state};
    mis    = state == RUN && |mask;
    busy   = state == RST || state == RUN;
    done   = state == DONE;
    nstate = state;
    case (state)
      IDLE: nstate = start ? (len == '0 ? DONE : RST) : IDLE;
      RST:  nstate = rc == RC_W'(RST_CYC - 1) ? RUN : RST;
      RUN:  nstate = k == nsteps - LEN_W'(1) ? DONE : RUN;
      DONE: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rc        <= '0;
      k         <= '0;
      pat       <= '0;
      nsteps    <= '0;
      fsm_rst_n <= 1'b0;
      fsm_a     <= 1'b0;
    end else begin
      state     <= nstate;
      rc        <= state == RST ? rc + RC_W'(1) : '0;
      k         <= k_n;
      pat       <= accept ? pattern : pat;
      nsteps    <= accept ? len_c : nsteps;
      // a len==0 run enters DONE straight from IDLE with the FSMs still held in reset
      fsm_rst_n <= nstate == RUN || (nstate == DONE && fsm_rst_n);
      fsm_a     <= nstate == RUN && a_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error     <= 1'b0;
      err_cnt   <= '0;
      err_step  <= '0;
      err_mask  <= '0;
      exp_state <= 3'd2;
    end else if (accept) begin
      error     <= 1'b0;
      err_cnt   <= '0;
      err_step  <= '0;
      err_mask  <= '0;
      exp_state <= 3'd2;
    end else if (state == RUN) begin
      // fsm_a carries pattern[k] during step k, the same bit the FSMs consume at this edge
      exp_state <= gnext(exp_state, fsm_a);
      if (mis) begin
        err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
        if (!error) begin
          error    <= 1'b1;
          err_step <= k;
          err_mask <= mask;
        end
      end
    end
  end
endmodule

// File: tb/tb_fsm_lockstep_sequencer.sv
// tb_fsm_lockstep_sequencer: directed runs checked each cycle against a plan-based reference
module tb_fsm_lockstep_sequencer;
  localparam int R = 2;
  logic clk = 1'b0, reset, start, fault;
  logic [31:0] pattern;
  logic [5:0]  len;
  logic [2:0]  fst, s_beh, s_gate, s_rom;
  logic fsm_rst_n, fsm_a, busy, done, error;
  logic [7:0] err_cnt;
  logic [5:0] err_step;
  logic [2:0] err_mask, exp_state;
  logic x_rst_n, x_a, x_busy, x_done, x_error;
  logic [1:0] x_cnt;
  logic [5:0] x_step;
  logic [2:0] x_mask, x_exp;
  int n_vec = 0, n_err = 0;
  bit chk_on = 0;
  logic m_busy, m_done, m_rstn, m_a, m_chk_a, m_err;
  int m_cnt, m_step;
  logic [2:0] m_mask, m_exp;
  logic [31:0] gp;
  int gL, done_at;
  logic [2:0] gexp[0:32];
  bit gmis[0:31];
  logic [2:0] obs[0:31];

  always #5 clk = ~clk;

  fsm_lockstep_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .s_beh(s_beh), .s_gate(s_gate), .s_rom(s_rom), .fsm_rst_n(fsm_rst_n), .fsm_a(fsm_a),
    .busy(busy), .done(done), .error(error), .err_cnt(err_cnt), .err_step(err_step),
    .err_mask(err_mask), .exp_state(exp_state));

  fsm_lockstep_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .s_beh(s_beh), .s_gate(s_gate), .s_rom(s_rom), .fsm_rst_n(x_rst_n), .fsm_a(x_a),
    .busy(x_busy), .done(x_done), .error(x_error), .err_cnt(x_cnt), .err_step(x_step),
    .err_mask(x_mask), .exp_state(x_exp));

  function automatic logic [2:0] gnext(input logic [2:0] s, input logic a);
    case (s)
      3'd2:    return 3'd6;
      3'd6:    return a ? 3'd7 : 3'd4;
      3'd4:    return 3'd5;
      3'd5:    return a ? 3'd6 : 3'd2;
      3'd7:    return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  always @(posedge clk) fst <= !fsm_rst_n ? 3'd2 : gnext(fst, fsm_a);
  assign s_beh  = fst;
  assign s_rom  = fst;
  assign s_gate = fault ? 3'd2 : fst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("fsm_rst_n", fsm_rst_n, m_rstn);
    if (m_chk_a) chk("fsm_a", fsm_a, m_a);
    chk("error", error, m_err);
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_step", err_step, m_step);
    chk("err_mask", err_mask, m_mask);
    chk("exp_state", exp_state, m_exp);
  end

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rstn = 0; m_a = 0; m_chk_a = 0;
    m_err = 0; m_cnt = 0; m_step = 0; m_mask = 0; m_exp = 3'd2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " fsm_rst_n"}, fsm_rst_n, 0);
    chk({tag, " fsm_a"}, fsm_a, 0);
    chk({tag, " error"}, error, 0);
    chk({tag, " err_cnt"}, err_cnt, 0);
    chk({tag, " err_step"}, err_step, 0);
    chk({tag, " err_mask"}, err_mask, 0);
    chk({tag, " exp_state"}, exp_state, 2);
  endtask

  task automatic plan(input logic [31:0] p, input logic [5:0] l, input bit f);
    gp = p;
    gL = l > 6'd32 ? 32 : int'(l);
    gexp[0] = 3'd2;
    for (int j = 0; j < gL; j++) begin
      gexp[j+1] = gnext(gexp[j], p[j]);
      gmis[j] = f && gexp[j] != 3'd2;
    end
  endtask

  task automatic set_res(input int upto);
    int cnt = 0, first = -1;
    for (int j = 0; j < upto; j++) if (gmis[j]) begin
      cnt++;
      if (first < 0) first = j;
    end
    m_cnt = cnt > 255 ? 255 : cnt;
    m_err = cnt > 0;
    m_step = first < 0 ? 0 : first;
    m_mask = first < 0 ? 3'b000 : 3'b010;
  endtask

  task automatic set_model(input int c);
    m_done = 0; m_chk_a = 0; m_a = 0;
    if (gL == 0) begin
      m_busy = 0; m_done = c == 1; m_rstn = 0; set_res(0); m_exp = 3'd2;
    end else if (c <= R) begin
      m_busy = 1; m_rstn = 0; set_res(0); m_exp = 3'd2;
    end else if (c <= R + gL) begin
      m_busy = 1; m_rstn = 1; m_chk_a = 1; m_a = gp[c-R-1];
      set_res(c - R - 1); m_exp = gexp[c-R-1];
    end else begin
      m_busy = 0; m_done = c == R + gL + 1; m_rstn = c == R + gL + 1;
      set_res(gL); m_exp = gexp[gL];
    end
  endtask

  task automatic run(input logic [31:0] p, input logic [5:0] l, input bit f,
                     input int abort_step, input bit poke);
    int last;
    plan(p, l, f);
    fault = f; pattern = p; len = l; start = 1;
    @(posedge clk); #1;
    start = 0; done_at = -1;
    last = gL == 0 ? 2 : R + gL + 2;
    for (int c = 1; c <= last; c++) begin
      set_model(c);
      if (c > R && c <= R + gL) obs[c-R-1] = exp_state;
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (poke && c == R + 2) begin start = 1; len = 6'd1; end else start = 0;
      if (abort_step >= 0 && c == R + 1 + abort_step) begin
        reset = 1; #1;
        model_reset();
        check_reset_values("abort");
        @(posedge clk); #1;
        reset = 0; fault = 0;
        return;
      end
      @(posedge clk); #1;
    end
    fault = 0;
  endtask

  initial begin
    logic [2:0] e2[0:5] = '{3'd2, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6};
    reset = 1; start = 0; pattern = 0; len = 0; fault = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check_reset_values("reset");
    chk_on = 1;
    run(32'h0, 6'd8, 0, -1, 0);
    chk("t1 done cycle", done_at, R + 9);
    chk("t1 err_cnt", err_cnt, 0);
    chk("t1 error", error, 0);
    chk("t1 final exp", exp_state, 2);
    run(32'h12, 6'd6, 0, -1, 0);
    for (int j = 0; j < 6; j++) chk("t2 exp seq", obs[j], e2[j]);
    chk("t2 error", error, 0);
    run(32'h0, 6'd8, 1, -1, 0);
    chk("t3 err_cnt", err_cnt, 6);
    chk("t3 err_step", err_step, 1);
    chk("t3 err_mask", err_mask, 3'b010);
    chk("t3 error", error, 1);
    chk("t4 sat err_cnt", x_cnt, 3);
    chk("t4 err_step", x_step, 1);
    run(32'h0, 6'd0, 0, -1, 0);
    chk("t5 done cycle", done_at, 1);
    chk("t5 err_cnt", err_cnt, 0);
    run(32'hFFFF_FFFF, 6'd8, 0, 3, 1);
    run(32'h0, 6'd4, 0, -1, 0);
    chk("t6 done cycle", done_at, R + 5);
    chk("t6 error", error, 0);
    run(32'hA5A5_3C3C, 6'd63, 0, -1, 0);
    chk("t7 clamp done cycle", done_at, R + 33);
    chk("t7 error", error, 0);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
